// File: rtl/sym_pkg.sv
// Shared constants for the streaming symmetry detector:
// check-mode codes and the fill/run state encoding.
package sym_pkg;

    localparam logic [1:0] MODE_PALIN  = 2'b00;
    localparam logic [1:0] MODE_ANTI   = 2'b01;
    localparam logic [1:0] MODE_REPEAT = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sym_stream_detector_if.sv
// Bit-stream input and match-report bundle
// between the bit source and the detector.
interface sym_stream_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic [1:0]       mode;
    logic             clear;
    logic             match;
    logic             filled;
    logic [CNT_W-1:0] match_cnt;
    logic [WIDTH-1:0] window;

    modport master (
        output in_valid, in_bit, mode, clear,
        input  match, filled, match_cnt, window
    );

    modport slave (
        input  in_valid, in_bit, mode, clear,
        output match, filled, match_cnt, window
    );
endinterface

// File: rtl/sym_check.sv
// Combinational symmetry test of one window
// under the selected check mode.
module sym_check
    import sym_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] window,
    input  logic [1:0]       mode,
    output logic             hit
);
    logic pal;
    logic anti;
    logic rep;

    always_comb begin
        pal  = 1'b1;
        anti = 1'b1;
        rep  = 1'b1;
        for (int i = 0; i < WIDTH / 2; i++) begin
            if (window[i] != window[WIDTH-1-i]) pal = 1'b0;
            if (window[i] == window[WIDTH-1-i]) anti = 1'b0;
            if (window[i] != window[i+WIDTH/2]) rep = 1'b0;
        end
        hit = 1'b0;
        unique case (mode)
            MODE_PALIN:  hit = pal;
            MODE_ANTI:   hit = anti;
            MODE_REPEAT: hit = rep;
            MODE_RSVD:   hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/sym_stream_detector.sv
// Serial window shifter with fill tracking, registered
// match pulse and saturating match counter.
module sym_stream_detector
    import sym_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sym_stream_detector_if.slave bus
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FULL = FW'(WIDTH);
    localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);

    state_t           state;
    logic [FW-1:0]    fill;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] win_nxt;
    logic [CNT_W-1:0] cnt;
    logic             match_q;
    logic             hit;
    logic             check_en;

    assign win_nxt  = {win[WIDTH-2:0], bus.in_bit};
    // The beat completing the fill is already checked.
    assign check_en = (state == ST_RUN) || (fill == LAST);

    sym_check #(.WIDTH(WIDTH)) u_check (
        .window(win_nxt),
        .mode  (bus.mode),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state   <= ST_FILL;
            fill    <= '0;
            win     <= '0;
            cnt     <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            if (bus.in_valid) begin
                win <= win_nxt;
                if (fill != FULL) fill <= fill + 1'b1;
                if (state == ST_FILL && fill == LAST) state <= ST_RUN;
                if (check_en && hit) begin
                    match_q <= 1'b1;
                    if (cnt != '1) cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.match     = match_q;
    assign bus.filled    = (fill == FULL);
    assign bus.match_cnt = cnt;
    assign bus.window    = win;
endmodule
